// File: rtl/shift_reg_piso.sv
// -----------------------------------------------------------------------------
// shift_reg_piso
//
// Parallel-in / serial-out shift register with a valid/ready load handshake.
// A word accepted on din is presented on sout MSB first, one bit per clock
// edge on which en is high. When en is low the shifter freezes. A new word
// may be loaded on the same edge that consumes the last bit of the current
// word, so back-to-back words stream without a gap.
//
// Parameters
//   N           parallel word width in bits (N >= 2)
//
// Ports
//   clk         clock, rising-edge active
//   res         asynchronous active-high reset
//   en          shift enable; one bit advances per edge while high
//   din         parallel word to serialize
//   load_valid  din is valid and offered for loading
//   load_ready  block accepts din on this cycle
//   sout        serial data out, MSB first
//   sout_valid  sout carries a valid data bit
//   busy        a word is being serialized
//   done        one-cycle pulse after the last bit of a word was shifted
// -----------------------------------------------------------------------------
module shift_reg_piso #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         res,
    input  logic         en,
    input  logic [N-1:0] din,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t         state;
    logic [N-1:0]   shreg;
    logic [CW-1:0]  cnt;
    logic           last_bit;
    logic           load_fire;

    // The edge that consumes bit 0 of the current word; the shifter is free
    // to take the next word on this same edge.
    assign last_bit   = (state == SHIFT) && en && (cnt == '0);
    assign load_ready = (state == IDLE) || last_bit;
    assign load_fire  = load_valid && load_ready;

    assign sout       = shreg[N-1];
    assign sout_valid = (state == SHIFT);
    assign busy       = (state == SHIFT);

    // NOTE: every register here uses non-blocking assignment so that all of
    // them update from the same pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            // A word completes whenever its last bit is consumed, even when
            // the following word is loaded on the very same edge.
            done <= last_bit;

            if (load_fire) begin
                shreg <= din;
                cnt   <= CW'(N - 1);
                state <= SHIFT;
            end else if ((state == SHIFT) && en) begin
                if (cnt != '0) begin
                    shreg <= {shreg[N-2:0], 1'b0};
                    cnt   <= cnt - 1'b1;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_reg_piso.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_piso
//
// Bench for shift_reg_piso. An N=8 instance is checked against a queue model:
// the queue holds the bits of the word still to be shown, its head is the
// expected sout, and a word completes when an enabled edge empties it. A
// second N=2 instance covers the minimum width.
// -----------------------------------------------------------------------------
module tb_shift_reg_piso;

    localparam int N = 8;

    logic         clk;
    logic         res;
    logic         en;
    logic [N-1:0] din;
    logic         load_valid;
    logic         load_ready;
    logic         sout;
    logic         sout_valid;
    logic         busy;
    logic         done;

    logic         en2;
    logic [1:0]   din2;
    logic         lv2;
    logic         ready2;
    logic         sout2;
    logic         valid2;
    logic         busy2;
    logic         done2;

    int n_checks;
    int n_pass;

    // Reference model for the N=8 instance.
    bit   q8[$];
    logic done_exp8;

    shift_reg_piso #(.N(N)) u_dut (
        .clk        (clk),
        .res        (res),
        .en         (en),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    shift_reg_piso #(.N(2)) u_dut2 (
        .clk        (clk),
        .res        (res),
        .en         (en2),
        .din        (din2),
        .load_valid (lv2),
        .load_ready (ready2),
        .sout       (sout2),
        .sout_valid (valid2),
        .busy       (busy2),
        .done       (done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A new word is accepted when nothing is pending, or when the single
    // remaining bit is being consumed on this edge.
    function automatic logic exp_ready8(input logic e);
        return (q8.size() == 0) || (e && (q8.size() == 1));
    endfunction

    task automatic model_reset();
        q8.delete();
        done_exp8 = 1'b0;
    endtask

    // Apply inputs for one cycle, advance the model, then return #1 after the
    // rising edge so outputs are sampled away from it.
    task automatic drive8(input logic e, input logic lv, input logic [N-1:0] d);
        logic fire;
        logic completed;
        en         = e;
        load_valid = lv;
        din        = d;
        fire       = lv && exp_ready8(e);
        completed  = 1'b0;
        if (e && (q8.size() > 0)) begin
            void'(q8.pop_front());
            if (q8.size() == 0) completed = 1'b1;
        end
        if (fire) begin
            for (int i = N - 1; i >= 0; i--) q8.push_back(d[i]);
        end
        @(posedge clk);
        done_exp8 = completed;
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({sout, sout_valid, busy, done, load_ready} !== 5'b00001)
            $display("FAIL reset_outputs: got %b expected 00001", {sout, sout_valid, busy, done, load_ready});
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({sout, sout_valid, busy, done, load_ready} !== 5'b00001)
            $display("FAIL reset_held_over_edge: got %b expected 00001", {sout, sout_valid, busy, done, load_ready});
        else n_pass++;
        #2 res = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        logic [7:0] w;
        w = 8'hA5;
        drive8(1'b1, 1'b1, w);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({sout, sout_valid, done} !== {w[7-i], 1'b1, 1'b0})
                $display("FAIL basic_bit%0d: got sout/valid/done %b expected %b", i, {sout, sout_valid, done}, {w[7-i], 2'b10});
            else n_pass++;
            drive8(1'b1, 1'b0, 8'h00);
        end
        n_checks++;
        if ({done, busy, sout_valid, load_ready} !== 4'b1001)
            $display("FAIL basic_done: got done/busy/valid/ready %b expected 1001", {done, busy, sout_valid, load_ready});
        else n_pass++;
        drive8(1'b1, 1'b0, 8'h00);
        n_checks++;
        if (done !== 1'b0) $display("FAIL basic_done_width: got %b expected 0", done);
        else n_pass++;
    endtask

    task automatic test_en_toggle();
        logic [7:0] w;
        w = 8'hC3;
        // en low while idle must not disturb the load.
        drive8(1'b0, 1'b1, w);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({sout, busy} !== {w[7-i], 1'b1})
                $display("FAIL toggle_bit%0d: got sout/busy %b expected %b", i, {sout, busy}, {w[7-i], 1'b1});
            else n_pass++;
            drive8(1'b0, 1'b1, 8'h3C);
            n_checks++;
            if ({sout, busy, done} !== {w[7-i], 2'b10})
                $display("FAIL toggle_hold%0d: got sout/busy/done %b expected %b", i, {sout, busy, done}, {w[7-i], 2'b10});
            else n_pass++;
            drive8(1'b1, 1'b0, 8'h00);
        end
        n_checks++;
        if ({done, busy} !== 2'b10)
            $display("FAIL toggle_done: got done/busy %b expected 10", {done, busy});
        else n_pass++;
        drive8(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        int          n_done;
        w      = 16'hF00F;
        n_done = 0;
        drive8(1'b1, 1'b1, 8'hF0);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if ({sout, sout_valid, busy} !== {w[15-i], 2'b11})
                $display("FAIL b2b_bit%0d: got sout/valid/busy %b expected %b", i, {sout, sout_valid, busy}, {w[15-i], 2'b11});
            else n_pass++;
            n_checks++;
            if (load_ready !== ((i == 7) || (i == 15)))
                $display("FAIL b2b_ready%0d: got %b expected %b", i, load_ready, (i == 7) || (i == 15));
            else n_pass++;
            if (done === 1'b1) n_done++;
            if (i < 7)       drive8(1'b1, 1'b1, 8'hF0);
            else if (i == 7) drive8(1'b1, 1'b1, 8'h0F);
            else             drive8(1'b1, 1'b0, 8'h00);
        end
        if (done === 1'b1) n_done++;
        n_checks++;
        if ({n_done, busy} !== {32'd2, 1'b0})
            $display("FAIL b2b_done_count: got %0d pulses busy %b expected 2 pulses busy 0", n_done, busy);
        else n_pass++;
        drive8(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_async_reset();
        logic [7:0] w;
        int         n_done;
        drive8(1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 3; i++) drive8(1'b1, 1'b0, 8'h00);
        en = 1'b0;
        #3 res = 1'b1;
        #1;
        n_checks++;
        if ({sout, sout_valid, busy, done, load_ready} !== 5'b00001)
            $display("FAIL async_reset_now: got %b expected 00001", {sout, sout_valid, busy, done, load_ready});
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({done, busy} !== 2'b00)
            $display("FAIL async_reset_no_done: got done/busy %b expected 00", {done, busy});
        else n_pass++;
        #2 res = 1'b0;
        model_reset();
        w      = 8'h81;
        n_done = 0;
        drive8(1'b1, 1'b1, w);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({sout, sout_valid} !== {w[7-i], 1'b1})
                $display("FAIL after_reset_bit%0d: got sout/valid %b expected %b", i, {sout, sout_valid}, {w[7-i], 1'b1});
            else n_pass++;
            if (done === 1'b1) n_done++;
            drive8(1'b1, 1'b0, 8'h00);
        end
        n_checks++;
        if ({n_done, done} !== {32'd0, 1'b1})
            $display("FAIL after_reset_done: got early %0d done %b expected 0 and 1", n_done, done);
        else n_pass++;
        drive8(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_ignore_load();
        logic [7:0] w;
        w = 8'hAA;
        drive8(1'b1, 1'b1, w);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (sout !== w[7-i])
                $display("FAIL ignore_bit%0d: got %b expected %b", i, sout, w[7-i]);
            else n_pass++;
            if (i == 3) begin
                n_checks++;
                if (load_ready !== 1'b0) $display("FAIL ignore_ready: got %b expected 0", load_ready);
                else n_pass++;
            end
            drive8(1'b1, (i == 3), (i == 3) ? 8'h55 : 8'h00);
        end
        n_checks++;
        if ({done, busy} !== 2'b10)
            $display("FAIL ignore_done: got done/busy %b expected 10", {done, busy});
        else n_pass++;
        drive8(1'b1, 1'b0, 8'h00);
        n_checks++;
        if ({busy, sout_valid} !== 2'b00)
            $display("FAIL ignore_no_capture: got busy/valid %b expected 00", {busy, sout_valid});
        else n_pass++;
    endtask

    task automatic test_n2();
        logic [1:0] got;
        logic [2:0] dn;
        en2  = 1'b1;
        lv2  = 1'b1;
        din2 = 2'b10;
        @(posedge clk); #1;
        lv2 = 1'b0;
        got[1] = sout2;
        dn[0]  = done2;
        @(posedge clk); #1;
        got[0] = sout2;
        dn[1]  = done2;
        @(posedge clk); #1;
        dn[2]  = done2;
        n_checks++;
        if ({got, dn} !== 5'b10100)
            $display("FAIL n2_sequence: got sout %b done %b expected sout 10 done 100", got, dn);
        else n_pass++;
        n_checks++;
        if ({busy2, ready2} !== 2'b01)
            $display("FAIL n2_idle: got busy/ready %b expected 01", {busy2, ready2});
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (done2 !== 1'b0) $display("FAIL n2_done_width: got %b expected 0", done2);
        else n_pass++;
        en2 = 1'b0;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            drive8(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4), 8'($urandom));
            n_checks++;
            if ({sout_valid, busy, done, load_ready} !==
                {(q8.size() != 0), (q8.size() != 0), done_exp8, exp_ready8(en)}) begin
                errs++;
                if (errs < 10)
                    $display("FAIL random_ctrl cycle %0d: got valid/busy/done/ready %b expected %b", c,
                             {sout_valid, busy, done, load_ready},
                             {(q8.size() != 0), (q8.size() != 0), done_exp8, exp_ready8(en)});
            end else n_pass++;
            if (q8.size() != 0) begin
                n_checks++;
                if (sout !== q8[0]) begin
                    errs++;
                    if (errs < 10) $display("FAIL random_sout cycle %0d: got %b expected %b", c, sout, q8[0]);
                end else n_pass++;
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        res        = 1'b1;
        en         = 1'b0;
        load_valid = 1'b0;
        din        = '0;
        en2        = 1'b0;
        lv2        = 1'b0;
        din2       = '0;
        model_reset();

        test_reset();
        test_basic();
        test_en_toggle();
        test_back_to_back();
        test_async_reset();
        test_ignore_load();
        test_n2();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_reg_piso.md
SHIFT_REG_PISO -- requirements
Module: shift_reg_piso

Interface
REQ-001 Parameter N, default 8: parallel word width in bits; legal range N >= 2.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 res  input  1  reset; asynchronous, active-high.
REQ-004 en  input  1  shift enable; advances the shifter one bit per clk edge while high.
REQ-005 din  input  N  parallel word to serialize.
REQ-006 load_valid  input  1  din is valid and offered for loading.
REQ-007 load_ready  output  1  block can accept din on this cycle.
REQ-008 sout  output  1  serial data out, MSB first.
REQ-009 sout_valid  output  1  sout carries a valid data bit.
REQ-010 busy  output  1  a word is being serialized.
REQ-011 done  output  1  one-cycle pulse after the last bit of a word has been shifted.

Function
REQ-012 The FSM SHALL have two states: IDLE and SHIFT.
REQ-013 The internal registers SHALL be an N-bit shift register shreg and a bit counter cnt of width $clog2(N).
REQ-014 A load SHALL occur on any rising clk edge where load_valid and load_ready are both 1: shreg <= din, cnt <= N-1, state <= SHIFT.
REQ-015 load_ready SHALL be 1 in IDLE, and 1 in SHIFT only when en=1 and cnt=0; it SHALL be 0 otherwise.
REQ-016 sout SHALL equal shreg[N-1] combinationally, and sout_valid and busy SHALL be 1 exactly when state=SHIFT.
REQ-017 In SHIFT with en=1 and cnt>0, each edge SHALL apply shreg <= {shreg[N-2:0],1'b0} and cnt <= cnt-1.
REQ-018 In SHIFT with en=1 and cnt=0 (last bit), the edge SHALL set done <= 1 and state <= IDLE.
  - Exception: if a load also occurs on that edge, REQ-014 takes precedence and state stays SHIFT, giving gapless back-to-back words.
REQ-019 In SHIFT with en=0, shreg, cnt, state and sout SHALL hold, and no load SHALL be accepted.
REQ-020 done SHALL be 1 for exactly one cycle per completed word, and 0 on all other cycles.
REQ-021 Each word SHALL be presented on sout for exactly N en-qualified cycles; first bit is din[N-1], last bit is din[0].
REQ-022 Latency SHALL be: first bit valid on sout the cycle after the load edge; done high the cycle after the edge that consumes bit 0.
REQ-023 load_valid while load_ready=0 SHALL be ignored, and the offered din SHALL not be captured.
REQ-024 en SHALL have no effect in IDLE.
REQ-025 All outputs SHALL be free of X after reset for any legal input sequence.

Reset
REQ-026 While res=1, regardless of clk: state=IDLE, shreg=0, cnt=0, done=0; hence sout=0, sout_valid=0, busy=0, load_ready=1.
REQ-027 Assertion of res mid-SHIFT SHALL abort the word immediately: no done pulse, and remaining bits are discarded.
REQ-028 After res deasserts, the first rising clk edge SHALL be able to accept a load.

Verification
REQ-029 N=8, load din=8'hA5 with en held 1 -> sout = 1,0,1,0,0,1,0,1 on 8 consecutive cycles, sout_valid high for those 8 cycles, done high for 1 cycle immediately after, then busy=0.
REQ-030 N=8, load 8'hC3 with en toggling 1,0,1,0,... -> each bit held while en=0, sequence 1,1,0,0,0,0,1,1 intact, done after the 8th enabled edge.
REQ-031 N=8, en=1, load_valid held high with 8'hF0 then 8'h0F offered at the last bit -> 16 contiguous valid bits 11110000 00001111, busy never drops, one done pulse per word.
REQ-032 N=8, load 8'hFF, assert res asynchronously after 3 bits -> sout=0, busy=0, load_ready=1 immediately, no done pulse; next load of 8'h81 serializes 1,0,0,0,0,0,0,1.
REQ-033 N=8, load 8'hAA, then pulse load_valid with din=8'h55 mid-word -> 8'h55 ignored, output 1,0,1,0,1,0,1,0 unchanged.
REQ-034 N=2, load 2'b10 -> sout 1 then 0, done on the third cycle after the load edge.
